arb_dut: RTL and testbench

//  Four-requester round-robin bus arbiter with one-hot registered grants.

---
 rtl/arb_dut.sv | 108 ++++++++++
 tb/tb_arb_dut.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_dut.sv
// arb_dut: four-requester round-robin bus arbiter with one-hot registered grants.
// A grant is held while its owner keeps requesting, then passes on in round-robin order.
`default_nettype none

module arb_dut (
   input  logic clock,
   input  logic rst,
   input  logic req1,
   input  logic req2,
   input  logic req3,
   input  logic req4,
   output logic gnt1,
   output logic gnt2,
   output logic gnt3,
   output logic gnt4
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] G1   = 3'd1;
   localparam logic [2:0] G2   = 3'd2;
   localparam logic [2:0] G3   = 3'd3;
   localparam logic [2:0] G4   = 3'd4;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [1:0] last;
   logic [1:0] last_nxt;
   logic [3:0] gnt;
   logic [3:0] gnt_nxt;
   logic [3:0] req;
   logic [1:0] owner;
   logic [1:0] base;
   logic [1:0] idx;
   logic [1:0] pick;
   logic       found;

   assign req = {req4, req3, req2, req1};

   // Owner index 0..3 for G1..G4; G4 (3'b100) wraps 2'b00 - 1 to 2'b11.
   assign owner = state[1:0] - 2'd1;
   assign base  = (state == IDLE) ? last : owner;

   // Search base+1, base+2, ... with wrap; an unknown request never wins.
   always_comb begin
      found = 1'b0;
      pick  = 2'd0;
      idx   = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = base + i[1:0];
         if (req[idx] && !found) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = {1'b0, pick} + 3'd1;
            end
         end
         G1, G2, G3, G4: begin
            if (!req[owner]) begin
               last_nxt  = owner;
               state_nxt = found ? ({1'b0, pick} + 3'd1) : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      gnt_nxt = 4'b0000;
      case (state_nxt)
         G1:      gnt_nxt = 4'b0001;
         G2:      gnt_nxt = 4'b0010;
         G3:      gnt_nxt = 4'b0100;
         G4:      gnt_nxt = 4'b1000;
         default: gnt_nxt = 4'b0000;
      endcase
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 2'd3;
         gnt   <= 4'b0000;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         gnt   <= gnt_nxt;
      end
   end

   assign gnt1 = gnt[0];
   assign gnt2 = gnt[1];
   assign gnt3 = gnt[2];
   assign gnt4 = gnt[3];

endmodule

`default_nettype wire

// File: tb/tb_arb_dut.sv
// tb_arb_dut: directed scenario tests for the arb_dut round-robin arbiter.
`default_nettype none

module tb_arb_dut;

   logic       clock;
   logic       rst;
   logic [3:0] req_v;
   logic       gnt1, gnt2, gnt3, gnt4;
   logic [3:0] gnt_v;
   logic [3:0] req_s;
   logic [3:0] gnt_prev;
   int         vectors;
   int         miscompares;
   int         inv_viol;

   assign gnt_v = {gnt4, gnt3, gnt2, gnt1};

   arb_dut dut (
      .clock (clock),
      .rst   (rst),
      .req1  (req_v[0]),
      .req2  (req_v[1]),
      .req3  (req_v[2]),
      .req4  (req_v[3]),
      .gnt1  (gnt1),
      .gnt2  (gnt2),
      .gnt3  (gnt3),
      .gnt4  (gnt4)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Invariant monitor: grants one-hot-or-zero, and every rise backed by its request.
   always @(posedge clock) req_s <= req_v;

   always @(negedge clock) begin
      if (!$onehot0(gnt_v)) begin
         $display("FAIL onehot0 at %0t: gnt=%b required at most one bit", $time, gnt_v);
         inv_viol <= inv_viol + 1;
      end else if (((gnt_v & ~gnt_prev) & ~req_s) != 4'b0000) begin
         $display("FAIL gnt_rise at %0t: gnt=%b prev=%b req_at_edge=%b required rise only with request",
                  $time, gnt_v, gnt_prev, req_s);
         inv_viol <= inv_viol + 1;
      end
      gnt_prev <= gnt_v;
   end

   task automatic test_reset;
      rst   = 1'b1;
      req_v = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         vectors++;
         if (gnt_v !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_hold cyc%0d: gnt=%b required 0000", i, gnt_v);
         end
      end
      rst = 1'b0;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_release: gnt=%b required 0001", gnt_v);
      end
      req_v = 4'b0000;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_idle: gnt=%b required 0000", gnt_v);
      end
   endtask

   task automatic test_single;
      // last = 1, so the search starts at 2 and finds 3.
      req_v = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         vectors++;
         if (gnt_v !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_hold cyc%0d: gnt=%b required 0100", i, gnt_v);
         end
      end
      req_v = 4'b0000;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0000) begin
         miscompares++;
         $display("FAIL single_release: gnt=%b required 0000", gnt_v);
      end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_seq [5];
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst = 1'b1;
      @(negedge clock);
      rst   = 1'b0;
      req_v = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         vectors++;
         if (gnt_v !== exp_seq[i]) begin
            miscompares++;
            $display("FAIL round_robin step%0d: gnt=%b required %b", i, gnt_v, exp_seq[i]);
         end
         req_v = 4'b1111 & ~exp_seq[i];
      end
      req_v = 4'b0000;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0000) begin
         miscompares++;
         $display("FAIL round_robin_idle: gnt=%b required 0000", gnt_v);
      end
   endtask

   task automatic test_no_preempt;
      req_v = 4'b0010;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0010) begin
         miscompares++;
         $display("FAIL preempt_grant: gnt=%b required 0010", gnt_v);
      end
      req_v = 4'b0011;
      @(negedge clock);
      req_v = 4'b0010;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (gnt_v !== 4'b0010) begin
            miscompares++;
            $display("FAIL preempt_hold cyc%0d: gnt=%b required 0010", i, gnt_v);
         end
         @(negedge clock);
      end
      req_v = 4'b0000;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0000) begin
         miscompares++;
         $display("FAIL preempt_idle: gnt=%b required 0000", gnt_v);
      end
   endtask

   task automatic test_pulse;
      // last = 2; a one-cycle pulse from master 1 earns exactly one grant cycle.
      req_v = 4'b0001;
      @(negedge clock);
      req_v = 4'b0000;
      vectors++;
      if (gnt_v !== 4'b0001) begin
         miscompares++;
         $display("FAIL pulse_grant: gnt=%b required 0001", gnt_v);
      end
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0000) begin
         miscompares++;
         $display("FAIL pulse_drop: gnt=%b required 0000", gnt_v);
      end
      #1 req_v = 4'b0100;
      #2 req_v = 4'b0000;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0000) begin
         miscompares++;
         $display("FAIL unsampled_pulse: gnt=%b required 0000", gnt_v);
      end
   endtask

   task automatic test_simultaneous;
      // last = 1: masters 1 and 4 both request, round-robin picks 4.
      req_v = 4'b1001;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b1000) begin
         miscompares++;
         $display("FAIL simul_first: gnt=%b required 1000", gnt_v);
      end
      req_v = 4'b0001;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0001) begin
         miscompares++;
         $display("FAIL simul_handover: gnt=%b required 0001", gnt_v);
      end
      req_v = 4'b0000;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0000) begin
         miscompares++;
         $display("FAIL simul_idle: gnt=%b required 0000", gnt_v);
      end
   endtask

   task automatic test_mid_reset;
      // last = 1: master 4 alone is granted.
      req_v = 4'b1000;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b1000) begin
         miscompares++;
         $display("FAIL midrst_grant: gnt=%b required 1000", gnt_v);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (gnt_v !== 4'b0000) begin
         miscompares++;
         $display("FAIL midrst_async_drop: gnt=%b required 0000", gnt_v);
      end
      req_v = 4'b1010;
      @(negedge clock);
      rst = 1'b0;
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0010) begin
         miscompares++;
         $display("FAIL midrst_restart: gnt=%b required 0010", gnt_v);
      end
      req_v = 4'b0000;
      @(negedge clock);
      @(negedge clock);
      vectors++;
      if (gnt_v !== 4'b0000) begin
         miscompares++;
         $display("FAIL midrst_idle: gnt=%b required 0000", gnt_v);
      end
   endtask

   task automatic test_invariants;
      vectors++;
      if (inv_viol !== 0) begin
         miscompares++;
         $display("FAIL invariants: violations=%0d required 0", inv_viol);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      inv_viol    = 0;
      gnt_prev    = 4'b0000;
      req_s       = 4'b0000;
      rst         = 1'b1;
      req_v       = 4'b0000;
      test_reset();
      test_single();
      test_round_robin();
      test_no_preempt();
      test_pulse();
      test_simultaneous();
      test_mid_reset();
      test_invariants();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
